// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg
// Shared definitions for the USB command responder: the FSM state encoding,
// ASCII constants used by the parser and response builder, and the response
// buffer depth.
package usb_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WAIT_EOL,
    S_DISCARD,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [7:0] CH_R  = 8'h72;  // 'r'
  localparam logic [7:0] CH_W  = 8'h77;  // 'w'
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_K  = 8'h4B;  // 'K'
  localparam logic [7:0] CH_Q  = 8'h3F;  // '?'

  localparam int RESP_DEPTH = 4;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  // Setting bit 5 maps 'R'/'W' onto 'r'/'w'; no other byte folds onto
  // 0x72 or 0x77, so this is a safe case-insensitive compare for the two
  // command letters.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return b | 8'h20;
  endfunction

endpackage

// File: rtl/usb_hex_nibble.sv
// usb_hex_nibble
// Combinational ASCII/hex helper.
//   ascii_i   : byte to decode
//   hex_ok_o  : ascii_i is 0-9, a-f or A-F
//   nib_o     : decoded nibble (0 when hex_ok_o is 0)
//   enc_hi_i  : nibble to encode (high digit of a response)
//   enc_lo_i  : nibble to encode (low digit of a response)
//   asc_hi_o  : uppercase ASCII for enc_hi_i
//   asc_lo_o  : uppercase ASCII for enc_lo_i
module usb_hex_nibble
  import usb_cmd_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic       hex_ok_o,
  output logic [3:0] nib_o,
  input  logic [3:0] enc_hi_i,
  input  logic [3:0] enc_lo_i,
  output logic [7:0] asc_hi_o,
  output logic [7:0] asc_lo_o
);

  // 0x37 + 10 = 'A'
  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    hex_ok_o = 1'b0;
    nib_o    = 4'h0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      hex_ok_o = 1'b1;
      nib_o    = ascii_i[3:0];
    end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                 (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
      hex_ok_o = 1'b1;
      nib_o    = ascii_i[3:0] + 4'd9;
    end
  end

  assign asc_hi_o = to_ascii(enc_hi_i);
  assign asc_lo_o = to_ascii(enc_lo_i);

endmodule

// File: rtl/usb_cmd_responder.sv
// usb_cmd_responder
// Parses ASCII "rAA<EOL>" / "wAADD<EOL>" commands from the host byte stream,
// performs single-cycle accesses on an 8-bit register bus and streams back
// ASCII responses ("K\r\n", "HH\r\n" or "?\r\n").
//   clk_48mhz      : clock
//   reset          : asynchronous, active-high
//   uart_out_*     : host-to-device byte stream (valid/ready)
//   uart_in_*      : device-to-host response stream (valid/ready)
//   reg_addr       : bus address, holds its last value
//   reg_wdata      : write data
//   reg_we, reg_re : one-cycle write / read strobes
//   reg_rdata      : read data, valid the cycle after reg_re
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for 'r'/'w'; bare EOLs ignored
// ADDR_HI/LO | collecting the two address digits
// DATA_HI/LO | collecting the two write-data digits
// WAIT_EOL   | command complete, expecting EOL
// DISCARD    | malformed line, swallow bytes until EOL, then answer '?'
// READ       | reg_re asserted
// CAPTURE    | reg_rdata sampled and formatted into the response buffer
// RESP       | shifting the response buffer out on uart_in
module usb_cmd_responder
  import usb_cmd_pkg::*;
#(
  parameter int unsigned LINE_TIMEOUT = 48_000_000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] uart_out_data,
  input  logic       uart_out_valid,
  output logic       uart_out_ready,
  output logic [7:0] uart_in_data,
  output logic       uart_in_valid,
  input  logic       uart_in_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  localparam int TW = (LINE_TIMEOUT > 0) ? $clog2(LINE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    (LINE_TIMEOUT == 0) ? '0 : TW'(LINE_TIMEOUT - 1);

  state_t state_q, state_d;
  logic   is_wr_q, is_wr_d;
  logic [7:0] addr_sh_q, addr_sh_d;
  logic [7:0] data_sh_q, data_sh_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic reg_we_q, reg_we_d;
  logic reg_re_q, reg_re_d;
  // Entry [0] is the byte currently presented on uart_in_data.
  logic [RESP_DEPTH-1:0][7:0] rsp_q, rsp_d;
  // Bytes remaining after the one currently presented.
  logic [1:0] rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       hex_ok;
  logic [3:0] nib;
  logic [7:0] rd_asc_hi, rd_asc_lo;

  usb_hex_nibble u_hex (
    .ascii_i  (uart_out_data),
    .hex_ok_o (hex_ok),
    .nib_o    (nib),
    .enc_hi_i (reg_rdata[7:4]),
    .enc_lo_i (reg_rdata[3:0]),
    .asc_hi_o (rd_asc_hi),
    .asc_lo_o (rd_asc_lo)
  );

  logic rx_state;
  logic timed_state;
  logic accept;
  logic eol;

  always_comb begin
    rx_state    = 1'b0;
    timed_state = 1'b0;
    case (state_q)
      S_IDLE: rx_state = 1'b1;
      S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO, S_WAIT_EOL, S_DISCARD: begin
        rx_state    = 1'b1;
        timed_state = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated by reset so the host sees no acceptance while reset is held.
  assign uart_out_ready = rx_state && !reset;
  assign accept         = uart_out_valid && uart_out_ready;
  assign eol            = is_eol(uart_out_data);

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    rsp_d       = rsp_q;
    rem_d       = rem_q;
    tmo_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (fold_case(uart_out_data) == CH_R || fold_case(uart_out_data) == CH_W) begin
            is_wr_d = (fold_case(uart_out_data) == CH_W);
            state_d = S_ADDR_HI;
          end else if (!eol) begin
            state_d = S_DISCARD;
          end
        end
      end

      S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO: begin
        if (accept) begin
          if (hex_ok) begin
            case (state_q)
              S_ADDR_HI: begin
                addr_sh_d = {addr_sh_q[3:0], nib};
                state_d   = S_ADDR_LO;
              end
              S_ADDR_LO: begin
                addr_sh_d = {addr_sh_q[3:0], nib};
                state_d   = is_wr_q ? S_DATA_HI : S_WAIT_EOL;
              end
              S_DATA_HI: begin
                data_sh_d = {data_sh_q[3:0], nib};
                state_d   = S_DATA_LO;
              end
              default: begin
                data_sh_d = {data_sh_q[3:0], nib};
                state_d   = S_WAIT_EOL;
              end
            endcase
          end else if (eol) begin
            // The line already ended; there is nothing left to discard.
            rsp_d   = {8'h00, CH_LF, CH_CR, CH_Q};
            rem_d   = 2'd2;
            state_d = S_RESP;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end

      S_WAIT_EOL: begin
        if (accept) begin
          if (eol) begin
            reg_addr_d = addr_sh_q;
            if (is_wr_q) begin
              reg_wdata_d = data_sh_q;
              reg_we_d    = 1'b1;
              rsp_d       = {8'h00, CH_LF, CH_CR, CH_K};
              rem_d       = 2'd2;
              state_d     = S_RESP;
            end else begin
              reg_re_d = 1'b1;
              state_d  = S_READ;
            end
          end else begin
            state_d = S_DISCARD;
          end
        end
      end

      S_DISCARD: begin
        if (accept && eol) begin
          rsp_d   = {8'h00, CH_LF, CH_CR, CH_Q};
          rem_d   = 2'd2;
          state_d = S_RESP;
        end
      end

      S_READ: state_d = S_CAPTURE;

      S_CAPTURE: begin
        rsp_d   = {CH_LF, CH_CR, rd_asc_lo, rd_asc_hi};
        rem_d   = 2'd3;
        state_d = S_RESP;
      end

      S_RESP: begin
        if (uart_in_ready) begin
          if (rem_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            // Next byte is loaded on the same edge as the transfer: no bubble.
            rsp_d = {8'h00, rsp_q[RESP_DEPTH-1:1]};
            rem_d = rem_q - 2'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Inactivity timer: only idle cycles inside a partial line count.
    if (LINE_TIMEOUT != 0 && timed_state && !accept) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      addr_sh_q   <= 8'h00;
      data_sh_q   <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rsp_q       <= '0;
      rem_q       <= 2'd0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      rsp_q       <= rsp_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
    end
  end

  assign uart_in_data  = rsp_q[0];
  assign uart_in_valid = (state_q == S_RESP);
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_we        = reg_we_q;
  assign reg_re        = reg_re_q;

endmodule

// File: tb/tb_usb_cmd_responder.sv
module tb_usb_cmd_responder;

  localparam int LT = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  always #5 clk = ~clk;

  usb_cmd_responder #(.LINE_TIMEOUT(LT)) dut (
    .clk_48mhz      (clk),
    .reset          (reset),
    .uart_out_data  (uart_out_data),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_we         (reg_we),
    .reg_re         (reg_re),
    .reg_rdata      (reg_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  logic [7:0] bus_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_b[$];
  acc_t       exp_acc[$];
  string      hexs = "0123456789ABCDEF";

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register bus model: rdata only meaningful the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_we) bus_mem[reg_addr] <= reg_wdata;
    reg_rdata <= reg_re ? bus_mem[reg_addr] : 8'($urandom);
  end

  // Response-side ready: random when back-pressure is enabled.
  initial begin
    uart_in_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      uart_in_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor / scoreboard
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         prev_we = 1'b0, prev_re = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_we = 1'b0;
      prev_re = 1'b0;
    end else begin
      if (prev_stall)
        chk(uart_in_valid && uart_in_data == prev_data, "stall_hold", {23'd0, uart_in_valid, uart_in_data}, {24'd1, prev_data});
      if (uart_in_valid)
        chk(!uart_out_ready, "rx_blocked_during_resp", uart_out_ready, 0);
      if (uart_in_valid && uart_in_ready) begin
        if (exp_b.size() == 0) chk(1'b0, "unexpected_byte", uart_in_data, 0);
        else begin
          logic [7:0] e;
          e = exp_b.pop_front();
          chk(uart_in_data == e, "resp_byte", uart_in_data, e);
        end
      end
      prev_stall = uart_in_valid && !uart_in_ready;
      prev_data  = uart_in_data;

      if (reg_we && reg_re) chk(1'b0, "both_strobes", 3, 1);
      if (reg_we) chk(!prev_we, "we_len", 2, 1);
      if (reg_re) chk(!prev_re, "re_len", 2, 1);
      if (reg_we || reg_re) begin
        if (exp_acc.size() == 0) chk(1'b0, "unexpected_strobe", {reg_we, reg_addr}, 0);
        else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk(a.we == reg_we, "strobe_kind", reg_we, a.we);
          chk(reg_addr == a.addr, "strobe_addr", reg_addr, a.addr);
          if (a.we) chk(reg_wdata == a.data, "strobe_wdata", reg_wdata, a.data);
        end
      end
      prev_we = reg_we;
      prev_re = reg_re;
    end
  end

  // Reference model: classifies a whole line (without EOL) by the grammar.
  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  task automatic model_line(input bq_t c);
    int n;
    logic [7:0] c0, a, d, v;
    acc_t acc;
    n = c.size();
    if (n == 0) return;
    c0 = c[0];
    if ((c0 == "r" || c0 == "R") && n == 3 && hexv(c[1]) >= 0 && hexv(c[2]) >= 0) begin
      a = 8'(hexv(c[1]) * 16 + hexv(c[2]));
      acc.we = 1'b0; acc.addr = a; acc.data = 8'h00;
      exp_acc.push_back(acc);
      v = ref_mem[a];
      exp_b.push_back(hexs[v / 16]);
      exp_b.push_back(hexs[v % 16]);
      exp_b.push_back(8'h0D);
      exp_b.push_back(8'h0A);
    end else if ((c0 == "w" || c0 == "W") && n == 5 && hexv(c[1]) >= 0 && hexv(c[2]) >= 0
                 && hexv(c[3]) >= 0 && hexv(c[4]) >= 0) begin
      a = 8'(hexv(c[1]) * 16 + hexv(c[2]));
      d = 8'(hexv(c[3]) * 16 + hexv(c[4]));
      acc.we = 1'b1; acc.addr = a; acc.data = d;
      exp_acc.push_back(acc);
      ref_mem[a] = d;
      exp_b.push_back("K");
      exp_b.push_back(8'h0D);
      exp_b.push_back(8'h0A);
    end else begin
      exp_b.push_back("?");
      exp_b.push_back(8'h0D);
      exp_b.push_back(8'h0A);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int at);
    bit r;
    bit done = 1'b0;
    uart_out_data  = b;
    uart_out_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      r = uart_out_ready;
      @(posedge clk);
      done = r;
    end
    #1;
    uart_out_valid = 1'b0;
    at = cyc;
    if (!done) chk(1'b0, "send_stuck", b, 0);
  endtask

  task automatic send_raw(input bq_t c, input int maxgap, output int at);
    foreach (c[i]) begin
      send_byte(c[i], at);
      if (maxgap > 0) repeat ($urandom_range(maxgap)) @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bq_t c, input logic [7:0] eol, input int maxgap, output int at);
    model_line(c);
    send_raw(c, maxgap, at);
    send_byte(eol, at);
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic wait_cond(input int sel, output int at);
    bit hit = 1'b0;
    at = -1;
    for (int k = 0; k < 30 && !hit; k++) begin
      case (sel)
        0: hit = reg_re;
        1: hit = reg_we;
        default: hit = uart_in_valid;
      endcase
      if (hit) at = cyc;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!hit) chk(1'b0, "wait_timeout", sel, 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_b.size() != 0 || uart_in_valid) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 2000) chk(1'b0, "drain_timeout", exp_b.size(), 0);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] v, input bit up);
    if (v < 10) return 8'h30 + {4'h0, v};
    return (up ? 8'h37 : 8'h57) + {4'h0, v};
  endfunction

  initial begin
    int n, at, t, len;
    bq_t q;
    logic [7:0] b;

    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[8'h3C] = 8'h7E;
    ref_mem[8'h3C] = 8'h7E;

    reset = 1'b1;
    uart_out_valid = 1'b0;
    uart_out_data = 8'h00;
    #1;
    chk(uart_out_ready == 1'b0, "rst_out_ready", uart_out_ready, 0);
    chk(uart_in_valid == 1'b0, "rst_in_valid", uart_in_valid, 0);
    chk(uart_in_data == 8'h00, "rst_in_data", uart_in_data, 0);
    chk({reg_we, reg_re, reg_addr, reg_wdata} == 18'd0, "rst_bus", {reg_we, reg_re, reg_addr, reg_wdata}, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk(uart_out_ready == 1'b1, "rel_out_ready", uart_out_ready, 1);

    // Read with fixed latency
    issue(s2q("R3c"), 8'h0D, 0, n);
    wait_cond(0, at);
    chk(at == n, "read_re_latency", at - n, 0);
    wait_cond(2, at);
    chk(at == n + 2, "read_resp_latency", at - n, 2);
    len = 0;
    while (uart_in_valid && len < 10) begin
      len++;
      @(posedge clk);
      #1;
    end
    chk(len == 4, "read_resp_cycles", len, 4);
    drain();

    // Write
    issue(s2q("w3CA5"), 8'h0A, 0, n);
    wait_cond(1, at);
    chk(at == n, "write_we_latency", at - n, 0);
    chk(uart_in_valid == 1'b1, "write_valid_with_we", uart_in_valid, 1);
    drain();

    // Errors and empty line
    issue(s2q("x12"), 8'h0A, 0, n);
    drain();
    issue(s2q("r1G"), 8'h0A, 0, n);
    drain();
    issue(s2q(""), 8'h0A, 0, n);
    repeat (6) @(posedge clk);
    #1;
    chk(uart_in_valid == 1'b0, "empty_line_silent", uart_in_valid, 0);

    // Back-pressure, back-to-back reads
    rnd_ready = 1'b1;
    issue(s2q("r00"), 8'h0A, 0, n);
    issue(s2q("r01"), 8'h0A, 0, n);
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // Timeout on a partial write, then a normal read
    send_raw(s2q("w12"), 0, n);
    repeat (LT) @(posedge clk);
    #1;
    issue(s2q("r05"), 8'h0A, 0, n);
    drain();

    // Reset after the first response byte
    issue(s2q("w10FF"), 8'h0A, 0, n);
    wait_cond(2, at);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk(uart_in_valid == 1'b0 && uart_in_data == 8'h00, "midrsp_rst_in", {uart_in_valid, uart_in_data}, 0);
    chk({reg_we, reg_re, reg_addr, reg_wdata} == 18'd0, "midrsp_rst_bus", {reg_we, reg_re, reg_addr, reg_wdata}, 0);
    chk(uart_out_ready == 1'b0, "midrsp_rst_ready", uart_out_ready, 0);
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk(uart_out_ready == 1'b1, "midrsp_rel_ready", uart_out_ready, 1);
    issue(s2q("r10"), 8'h0D, 0, n);
    drain();

    // Randomized traffic
    rnd_ready = 1'b1;
    for (int l = 0; l < 150; l++) begin
      q.delete();
      t = $urandom % 8;
      if (t <= 2) begin
        q.push_back(($urandom % 2) ? "R" : "r");
        repeat (2) q.push_back(hexc(4'($urandom), 1'($urandom)));
      end else if (t <= 5) begin
        q.push_back(($urandom % 2) ? "W" : "w");
        repeat (4) q.push_back(hexc(4'($urandom), 1'($urandom)));
      end else if (t == 6) begin
        repeat ($urandom_range(1, 6)) begin
          b = 8'($urandom);
          while (b == 8'h0A || b == 8'h0D) b = 8'($urandom);
          q.push_back(b);
        end
      end
      issue(q, ($urandom % 2) ? 8'h0D : 8'h0A, 2, n);
      if ($urandom % 4 == 0) issue(s2q(""), 8'h0A, 0, n);
    end
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk(exp_b.size() == 0, "bytes_left", exp_b.size(), 0);
    chk(exp_acc.size() == 0, "strobes_left", exp_acc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
